decred_result_collector: RTL and testbench
==========================================

Name: decred_result_collector

Overview:
- Hash-side readback stage that sits downstream of the decred_hash_macro array and upstream of the SPI register file in decred_controller.
- Round-robin scans DATA_AVAILABLE and borrows the shared read bus (MACRO_RD_SELECT / HASH_ADDR / DATA_FROM_HASH) by request/grant.
- Reads a 4-byte winning nonce from the flagged macro and pushes {macro index, nonce} into a small result FIFO.
- The host drains the FIFO through the controller; IRQ_PENDING drives the IRQ_OUT path.

Parameters:
- NUMBER_OF_MACROS, 4, number of hash macros scanned.
- MACRO_IDX_W, 2, width of macro index (clog2 of NUMBER_OF_MACROS).
- RESULT_ADDR_BASE, 6'h38, HASH_ADDR of nonce byte 0; bytes at BASE..BASE+3.
- FIFO_DEPTH, 8, result FIFO entries (power of two).

Ports:
- CLK  in  1  m1_clk_local domain, all logic rising-edge.
- RESET  in  1  synchronous, active-high.
- DATA_AVAILABLE  in  NUMBER_OF_MACROS  per-macro result-ready flags.
- BUS_REQ  out  1  request for shared read bus.
- BUS_GNT  in  1  controller grant; collector drives bus only while high.
- MACRO_RD_SELECT  out  NUMBER_OF_MACROS  one-hot read select, 0 when idle.
- HASH_ADDR  out  6  read address, 0 when idle.
- DATA_FROM_HASH  in  8  read data, valid one cycle after address/select.
- RESULT_VALID  out  1  FIFO non-empty.
- RESULT_DATA  out  32  head-entry nonce.
- RESULT_MACRO  out  MACRO_IDX_W  head-entry macro index.
- RESULT_POP  in  1  pop head entry (ignored when empty).
- RESULT_COUNT  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- IRQ_PENDING  out  1  equals RESULT_VALID.

Behaviour:
- Clocking and reset: one clock (CLK); reset is synchronous and active-high (RESET).
- Reset values: BUS_REQ=0, MACRO_RD_SELECT=0, HASH_ADDR=0, RESULT_VALID=0, RESULT_COUNT=0, IRQ_PENDING=0, RESULT_DATA/RESULT_MACRO=0.
- Reset also clears the round-robin pointer (to 0), the service mask, and the FIFO.
- Reset mid-read aborts the read; no partial entry is pushed.
- Eligible(i) = DATA_AVAILABLE[i] & ~mask[i].
- mask[i] is set when the entry for macro i is pushed. It clears on any cycle DATA_AVAILABLE[i]==0, which prevents a double push while the macro deasserts its flag.
- FSM IDLE:
  - If any eligible bit is set and RESULT_COUNT<FIFO_DEPTH, pick the first eligible index at or after rr_ptr (wrapping), latch it as sel, go to REQ.
  - If the FIFO is full, stay in IDLE; flags remain pending (no loss, no overflow).
- FSM REQ: BUS_REQ=1. On BUS_GNT=1 go to READ with k=0.
- FSM READ:
  - BUS_REQ=1, MACRO_RD_SELECT=onehot(sel), HASH_ADDR=BASE+k for k=0..3 (4 cycles).
  - DATA_FROM_HASH is sampled the cycle after each address into byte k, giving nonce[8k+7:8k] (little-endian).
  - After the last address, one CAPTURE cycle: select still held, HASH_ADDR=BASE+3, byte 3 sampled.
- FSM PUSH: bus released (select=0, addr=0, BUS_REQ=0). Write {sel, nonce} to the FIFO, set mask[sel], rr_ptr=sel+1 mod NUMBER_OF_MACROS, return to IDLE.
- Latency: grant to push is 6 cycles; back-to-back services are possible from the next IDLE.
- Grant loss: if BUS_GNT drops during READ/CAPTURE, drive select/addr to 0 that cycle, discard captured bytes, return to REQ with the same sel (restart at k=0).
- FIFO:
  - First-word-fall-through: RESULT_DATA/RESULT_MACRO show the head whenever RESULT_VALID=1.
  - Pop is registered; the next entry appears the cycle after the pop.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pop when empty is ignored, with no pointer movement.
  - Pointers wrap at FIFO_DEPTH.
- No combinational path from inputs to MACRO_RD_SELECT/HASH_ADDR/BUS_REQ; all three are registered.

Test Plan:
- Single result: DATA_AVAILABLE=4'b0100, GNT tied 1, macro 2 returns bytes 0x78,0x56,0x34,0x12 at 0x38..0x3B -> select 4'b0100, addresses 0x38..0x3B on consecutive cycles, RESULT_DATA=0x12345678, RESULT_MACRO=2, IRQ_PENDING=1, no second push while flag held high.
- Round robin: DATA_AVAILABLE=4'b1111 after reset, each flag cleared after its read -> push order macros 0,1,2,3; repeat with rr_ptr=2 -> order 2,3,0,1.
- Grant loss: GNT drops at k=2 and returns 3 cycles later -> bus goes to 0 immediately, read restarts at 0x38, exactly one correct entry pushed.
- FIFO full: 8 results queued, no pops, macro 1 asserts -> no BUS_REQ, RESULT_COUNT=8; pop once -> macro 1 serviced, count returns to 8.
- Simultaneous push/pop at count=3 -> count stays 3, head advances, new entry at tail; pop with count=0 -> no change.
- Reset mid-READ at k=1 -> next cycle all outputs 0, FIFO empty, mask clear, and a still-high flag is re-serviced from scratch.

Source files
------------

// File: rtl/decred_result_collector_if.sv
// rtl/decred_result_collector_if.sv - Shared hash read bus and result FIFO signals of the result collector
interface decred_result_collector_if #(
  parameter int NUMBER_OF_MACROS = 4,
  parameter int MACRO_IDX_W      = 2,
  parameter int FIFO_DEPTH       = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUMBER_OF_MACROS-1:0] DATA_AVAILABLE;
  logic                        BUS_REQ;
  logic                        BUS_GNT;
  logic [NUMBER_OF_MACROS-1:0] MACRO_RD_SELECT;
  logic [5:0]                  HASH_ADDR;
  logic [7:0]                  DATA_FROM_HASH;
  logic                        RESULT_VALID;
  logic [31:0]                 RESULT_DATA;
  logic [MACRO_IDX_W-1:0]      RESULT_MACRO;
  logic                        RESULT_POP;
  logic [CNT_W-1:0]            RESULT_COUNT;
  logic                        IRQ_PENDING;

  modport master (
    input  DATA_AVAILABLE, BUS_GNT, DATA_FROM_HASH, RESULT_POP,
    output BUS_REQ, MACRO_RD_SELECT, HASH_ADDR, RESULT_VALID, RESULT_DATA,
           RESULT_MACRO, RESULT_COUNT, IRQ_PENDING
  );

  modport slave (
    output DATA_AVAILABLE, BUS_GNT, DATA_FROM_HASH, RESULT_POP,
    input  BUS_REQ, MACRO_RD_SELECT, HASH_ADDR, RESULT_VALID, RESULT_DATA,
           RESULT_MACRO, RESULT_COUNT, IRQ_PENDING
  );
endinterface

// File: rtl/decred_result_collector.sv
// rtl/decred_result_collector.sv - Round-robin nonce readback from hash macros into a FWFT result FIFO
module decred_result_collector #(
  parameter int         NUMBER_OF_MACROS = 4,
  parameter int         MACRO_IDX_W      = 2,
  parameter logic [5:0] RESULT_ADDR_BASE = 6'h38,
  parameter int         FIFO_DEPTH       = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  decred_result_collector_if.master bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDX1_W = MACRO_IDX_W + 1;
  localparam int ENT_W  = MACRO_IDX_W + 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_READ    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_PUSH    = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [MACRO_IDX_W-1:0]      sel_q, sel_d;
  logic [MACRO_IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]                  k_q, k_d;
  logic [31:0]                 nonce_q, nonce_d;
  logic [NUMBER_OF_MACROS-1:0] mask_q, mask_d;
  logic                        bus_req_q, bus_req_d;
  logic [NUMBER_OF_MACROS-1:0] rd_select_q, rd_select_d;
  logic [5:0]                  hash_addr_q, hash_addr_d;
  logic [ENT_W-1:0]            fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]            fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic [NUMBER_OF_MACROS-1:0] eligible;
  logic [IDX1_W-1:0]           cand;
  logic [MACRO_IDX_W-1:0]      pick;
  logic                        found;
  logic [1:0]                  byte_idx;
  logic                        push, pop;
  logic [ENT_W-1:0]            head;

  always_comb begin
    eligible = bus.DATA_AVAILABLE & ~mask_q;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int o = 0; o < NUMBER_OF_MACROS; o++) begin
      cand = {1'b0, rr_ptr_q} + IDX1_W'(o);
      if (cand >= IDX1_W'(NUMBER_OF_MACROS)) cand = cand - IDX1_W'(NUMBER_OF_MACROS);
      if (!found && eligible[cand[MACRO_IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[MACRO_IDX_W-1:0];
      end
    end

    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    k_d      = k_q;
    nonce_d  = nonce_q;
    byte_idx = k_q - 2'd1;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found && (count_q < CNT_W'(FIFO_DEPTH))) begin
          sel_d   = pick;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.BUS_GNT) begin
          state_d = ST_READ;
          k_d     = 2'd0;
        end
      end
      ST_READ: begin
        if (!bus.BUS_GNT) begin
          state_d = ST_REQ;
          k_d     = 2'd0;
          nonce_d = '0;
        end else begin
          // Data lags the address by one cycle, so this cycle carries byte k-1.
          if (k_q != 2'd0) nonce_d[{byte_idx, 3'b000} +: 8] = bus.DATA_FROM_HASH;
          if (k_q == 2'd3) state_d = ST_CAPTURE;
          else             k_d     = k_q + 2'd1;
        end
      end
      ST_CAPTURE: begin
        if (!bus.BUS_GNT) begin
          state_d = ST_REQ;
          k_d     = 2'd0;
          nonce_d = '0;
        end else begin
          nonce_d[31:24] = bus.DATA_FROM_HASH;
          state_d        = ST_PUSH;
        end
      end
      ST_PUSH: begin
        push     = 1'b1;
        rr_ptr_d = (sel_q == MACRO_IDX_W'(NUMBER_OF_MACROS - 1)) ? '0 : sel_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are registered copies of what the next state will drive.
    bus_req_d   = (state_d == ST_REQ) || (state_d == ST_READ) || (state_d == ST_CAPTURE);
    rd_select_d = '0;
    hash_addr_d = '0;
    if (state_d == ST_READ) begin
      rd_select_d = NUMBER_OF_MACROS'(1) << sel_d;
      hash_addr_d = RESULT_ADDR_BASE + {4'b0000, k_d};
    end else if (state_d == ST_CAPTURE) begin
      rd_select_d = NUMBER_OF_MACROS'(1) << sel_d;
      hash_addr_d = RESULT_ADDR_BASE + 6'd3;
    end

    mask_d = mask_q & bus.DATA_AVAILABLE;
    if (push) mask_d = mask_d | (NUMBER_OF_MACROS'(1) << sel_q);
  end

  always_comb begin
    pop    = bus.RESULT_POP && (count_q != '0);
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = {sel_q, nonce_q};
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      k_q         <= '0;
      nonce_q     <= '0;
      mask_q      <= '0;
      bus_req_q   <= 1'b0;
      rd_select_q <= '0;
      hash_addr_q <= '0;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      k_q         <= k_d;
      nonce_q     <= nonce_d;
      mask_q      <= mask_d;
      bus_req_q   <= bus_req_d;
      rd_select_q <= rd_select_d;
      hash_addr_q <= hash_addr_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign head                = fifo_q[rd_ptr_q];
  assign bus.BUS_REQ         = bus_req_q;
  assign bus.MACRO_RD_SELECT = rd_select_q;
  assign bus.HASH_ADDR       = hash_addr_q;
  assign bus.RESULT_VALID    = (count_q != '0);
  assign bus.RESULT_DATA     = (count_q != '0) ? head[31:0] : '0;
  assign bus.RESULT_MACRO    = (count_q != '0) ? head[32 +: MACRO_IDX_W] : '0;
  assign bus.RESULT_COUNT    = count_q;
  assign bus.IRQ_PENDING     = (count_q != '0);
endmodule

// File: tb/tb_decred_result_collector.sv
// tb/tb_decred_result_collector.sv - Directed vector bench for decred_result_collector
module tb_decred_result_collector;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decred_result_collector_if bus_if ();
  decred_result_collector dut (.CLK(clk), .RESET(reset), .bus(bus_if));

  typedef struct {
    logic [3:0]  da;
    logic        gnt;
    logic        pop;
    logic        req;
    logic [3:0]  sel;
    logic [5:0]  addr;
    logic        valid;
    logic [3:0]  cnt;
    logic [31:0] data;
    logic [1:0]  mac;
  } vec_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] nonce_mem [4];
  logic [3:0]  prev_sel  = 4'b0;
  logic [5:0]  prev_addr = 6'h0;

  // Hash macro read port: returns the byte addressed on the previous cycle.
  always @(negedge clk) begin : hash_model
    logic [7:0] b;
    logic [1:0] bi;
    b  = 8'h00;
    bi = prev_addr[1:0];
    for (int m = 0; m < 4; m++)
      if (prev_sel[m] && prev_addr >= 6'h38 && prev_addr <= 6'h3B) b = nonce_mem[m][{bi, 3'b000} +: 8];
    bus_if.DATA_FROM_HASH = b;
    prev_sel  = bus_if.MACRO_RD_SELECT;
    prev_addr = bus_if.HASH_ADDR;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.DATA_AVAILABLE = 4'b0;
    bus_if.BUS_GNT        = 1'b0;
    bus_if.RESULT_POP     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_count(input logic [3:0] exp, input int budget, input string name);
    int t = 0;
    while (bus_if.RESULT_COUNT !== exp && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(bus_if.RESULT_COUNT), 64'(exp));
  endtask

  task automatic wait_addr(input logic [5:0] a, input int budget, input string name);
    int t = 0;
    while (bus_if.HASH_ADDR !== a && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(bus_if.HASH_ADDR), 64'(a));
  endtask

  task automatic pop_expect(input logic [1:0] m, input string name);
    chk({name, "_valid"}, 64'(bus_if.RESULT_VALID), 64'(1));
    chk({name, "_macro"}, 64'(bus_if.RESULT_MACRO), 64'(m));
    chk({name, "_data"}, 64'(bus_if.RESULT_DATA), 64'(nonce_mem[m]));
    bus_if.RESULT_POP = 1'b1;
    @(negedge clk);
    bus_if.RESULT_POP = 1'b0;
  endtask

  task automatic service(input logic [1:0] m, input logic [3:0] cnt_after, input string name);
    bus_if.DATA_AVAILABLE = 4'b0001 << m;
    wait_count(cnt_after, 30, name);
    bus_if.DATA_AVAILABLE = 4'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [12];
    logic [1:0] order_a [4];
    logic [1:0] order_b [4];
    logic [1:0] order_f [8];
    int         req_seen;
    int         t;
    logic       saw_req;
    logic       at_push;

    nonce_mem[0] = 32'h0BADF00D;
    nonce_mem[1] = 32'hCAFEBABE;
    nonce_mem[2] = 32'h12345678;
    nonce_mem[3] = 32'hDEADBEEF;
    order_a = '{2'd0, 2'd1, 2'd2, 2'd3};
    order_b = '{2'd2, 2'd3, 2'd0, 2'd1};
    order_f = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};

    //                da       g     p     req   sel      addr   v     cnt   data          mac
    vecs[0]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0000, 6'h00, 1'b0, 4'd0, 32'h0,        2'd0};
    vecs[1]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 6'h38, 1'b0, 4'd0, 32'h0,        2'd0};
    vecs[2]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 6'h39, 1'b0, 4'd0, 32'h0,        2'd0};
    vecs[3]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 6'h3A, 1'b0, 4'd0, 32'h0,        2'd0};
    vecs[4]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 6'h3B, 1'b0, 4'd0, 32'h0,        2'd0};
    vecs[5]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 6'h3B, 1'b0, 4'd0, 32'h0,        2'd0};
    vecs[6]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 6'h00, 1'b0, 4'd0, 32'h0,        2'd0};
    vecs[7]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 6'h00, 1'b1, 4'd1, 32'h12345678, 2'd2};
    vecs[8]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 6'h00, 1'b1, 4'd1, 32'h12345678, 2'd2};
    vecs[9]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 6'h00, 1'b1, 4'd1, 32'h12345678, 2'd2};
    vecs[10] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 6'h00, 1'b0, 4'd0, 32'h0,        2'd0};
    vecs[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 6'h00, 1'b0, 4'd0, 32'h0,        2'd0};

    do_reset();
    chk("rst_req",   64'(bus_if.BUS_REQ),         64'(0));
    chk("rst_sel",   64'(bus_if.MACRO_RD_SELECT), 64'(0));
    chk("rst_addr",  64'(bus_if.HASH_ADDR),       64'(0));
    chk("rst_valid", 64'(bus_if.RESULT_VALID),    64'(0));
    chk("rst_cnt",   64'(bus_if.RESULT_COUNT),    64'(0));
    chk("rst_irq",   64'(bus_if.IRQ_PENDING),     64'(0));
    chk("rst_data",  64'(bus_if.RESULT_DATA),     64'(0));

    for (int i = 0; i < 12; i++) begin
      bus_if.DATA_AVAILABLE = vecs[i].da;
      bus_if.BUS_GNT        = vecs[i].gnt;
      bus_if.RESULT_POP     = vecs[i].pop;
      @(negedge clk);
      chk($sformatf("v%0d_req", i),   64'(bus_if.BUS_REQ),         64'(vecs[i].req));
      chk($sformatf("v%0d_sel", i),   64'(bus_if.MACRO_RD_SELECT), 64'(vecs[i].sel));
      chk($sformatf("v%0d_addr", i),  64'(bus_if.HASH_ADDR),       64'(vecs[i].addr));
      chk($sformatf("v%0d_valid", i), 64'(bus_if.RESULT_VALID),    64'(vecs[i].valid));
      chk($sformatf("v%0d_irq", i),   64'(bus_if.IRQ_PENDING),     64'(vecs[i].valid));
      chk($sformatf("v%0d_cnt", i),   64'(bus_if.RESULT_COUNT),    64'(vecs[i].cnt));
      chk($sformatf("v%0d_data", i),  64'(bus_if.RESULT_DATA),     64'(vecs[i].data));
      chk($sformatf("v%0d_mac", i),   64'(bus_if.RESULT_MACRO),    64'(vecs[i].mac));
    end
    bus_if.RESULT_POP = 1'b0;

    // Round robin from pointer 0, then from pointer 2.
    do_reset();
    bus_if.BUS_GNT        = 1'b1;
    bus_if.DATA_AVAILABLE = 4'b1111;
    wait_count(4'd4, 60, "rr_a_cnt");
    bus_if.DATA_AVAILABLE = 4'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) pop_expect(order_a[i], $sformatf("rr_a%0d", i));
    service(2'd1, 4'd1, "rr_m1_cnt");
    pop_expect(2'd1, "rr_m1");
    bus_if.DATA_AVAILABLE = 4'b1111;
    wait_count(4'd4, 60, "rr_b_cnt");
    bus_if.DATA_AVAILABLE = 4'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) pop_expect(order_b[i], $sformatf("rr_b%0d", i));

    // Grant drops while byte 2 is addressed.
    do_reset();
    bus_if.BUS_GNT        = 1'b1;
    bus_if.DATA_AVAILABLE = 4'b0001;
    wait_addr(6'h3A, 20, "gl_reach_k2");
    bus_if.BUS_GNT = 1'b0;
    @(negedge clk);
    chk("gl_sel_off",  64'(bus_if.MACRO_RD_SELECT), 64'(0));
    chk("gl_addr_off", 64'(bus_if.HASH_ADDR),       64'(0));
    chk("gl_req_held", 64'(bus_if.BUS_REQ),         64'(1));
    repeat (2) @(negedge clk);
    chk("gl_sel_wait", 64'(bus_if.MACRO_RD_SELECT), 64'(0));
    bus_if.BUS_GNT = 1'b1;
    @(negedge clk);
    chk("gl_restart_addr", 64'(bus_if.HASH_ADDR),       64'(6'h38));
    chk("gl_restart_sel",  64'(bus_if.MACRO_RD_SELECT), 64'(4'b0001));
    wait_count(4'd1, 20, "gl_cnt");
    repeat (10) @(negedge clk);
    chk("gl_single", 64'(bus_if.RESULT_COUNT), 64'(1));
    bus_if.DATA_AVAILABLE = 4'b0;
    pop_expect(2'd0, "gl_entry");

    // FIFO full: a pending flag waits without requesting the bus.
    do_reset();
    bus_if.BUS_GNT = 1'b1;
    for (int i = 0; i < 8; i++) service(2'(i % 4), 4'(i + 1), $sformatf("full_fill%0d", i));
    bus_if.DATA_AVAILABLE = 4'b0010;
    req_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.BUS_REQ) req_seen++;
    end
    chk("full_no_req", 64'(req_seen), 64'(0));
    chk("full_cnt",    64'(bus_if.RESULT_COUNT), 64'(8));
    pop_expect(2'd0, "full_pop");
    wait_count(4'd8, 30, "full_refill");
    bus_if.DATA_AVAILABLE = 4'b0;
    for (int i = 0; i < 8; i++) pop_expect(order_f[i], $sformatf("full_drain%0d", i));
    chk("full_empty", 64'(bus_if.RESULT_COUNT), 64'(0));

    // Push and pop on the same edge at count 3, then pop on empty.
    do_reset();
    bus_if.BUS_GNT = 1'b1;
    for (int i = 0; i < 3; i++) service(2'(i), 4'(i + 1), $sformatf("pp_fill%0d", i));
    bus_if.DATA_AVAILABLE = 4'b1000;
    saw_req = 1'b0;
    at_push = 1'b0;
    t = 0;
    while (!at_push && t < 20) begin
      @(negedge clk);
      t++;
      if (saw_req && !bus_if.BUS_REQ) at_push = 1'b1;
      if (bus_if.BUS_REQ) saw_req = 1'b1;
    end
    chk("pp_found_push", 64'(at_push), 64'(1));
    chk("pp_cnt_before", 64'(bus_if.RESULT_COUNT), 64'(3));
    bus_if.RESULT_POP = 1'b1;
    @(negedge clk);
    bus_if.RESULT_POP = 1'b0;
    chk("pp_cnt_after", 64'(bus_if.RESULT_COUNT), 64'(3));
    bus_if.DATA_AVAILABLE = 4'b0;
    for (int i = 1; i < 4; i++) pop_expect(2'(i), $sformatf("pp_drain%0d", i));
    bus_if.RESULT_POP = 1'b1;
    @(negedge clk);
    bus_if.RESULT_POP = 1'b0;
    chk("pp_empty_cnt",   64'(bus_if.RESULT_COUNT), 64'(0));
    chk("pp_empty_valid", 64'(bus_if.RESULT_VALID), 64'(0));
    service(2'd2, 4'd1, "pp_after_cnt");
    chk("pp_after_macro", 64'(bus_if.RESULT_MACRO), 64'(2));
    chk("pp_after_data",  64'(bus_if.RESULT_DATA),  64'(nonce_mem[2]));

    // Reset while byte 1 is addressed; one stale entry is still queued.
    bus_if.DATA_AVAILABLE = 4'b0100;
    wait_addr(6'h39, 20, "mr_reach_k1");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_req",   64'(bus_if.BUS_REQ),         64'(0));
    chk("mr_sel",   64'(bus_if.MACRO_RD_SELECT), 64'(0));
    chk("mr_addr",  64'(bus_if.HASH_ADDR),       64'(0));
    chk("mr_cnt",   64'(bus_if.RESULT_COUNT),    64'(0));
    chk("mr_valid", 64'(bus_if.RESULT_VALID),    64'(0));
    chk("mr_irq",   64'(bus_if.IRQ_PENDING),     64'(0));
    chk("mr_data",  64'(bus_if.RESULT_DATA),     64'(0));
    wait_count(4'd1, 30, "mr_reservice_cnt");
    bus_if.DATA_AVAILABLE = 4'b0;
    pop_expect(2'd2, "mr_reservice");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
